spi_slave_if: RTL
=================

Name: spi_slave_if

Overview:
- SPI slave front end placed directly upstream of the single-port RAM stage.
- Deserialises MOSI frames into 10-bit command/data words: bits [9:8] are the opcode and bits [7:0] are the address or data.
- Presents each word on rx_data with a one-cycle rx_valid pulse.
- For read-data frames, captures the RAM's tx_data when tx_valid is high and serialises it back on MISO.

Parameters:
- FRAME_W, 10, bits per MOSI frame (opcode plus payload).
- DATA_W, 8, bits per MISO read-back word.

Ports:
- clk  input  1  system clock; SPI bit clock is clk, one bit per cycle.
- reset  input  1  synchronous, active-high reset.
- ss_n  input  1  slave select, active low.
- mosi  input  1  serial data in, MSB first, sampled on rising clk.
- miso  output  1  serial data out, MSB first.
- rx_data  output  FRAME_W  last completed frame.
- rx_valid  output  1  one-cycle strobe: rx_data is new.
- tx_data  input  DATA_W  read data from the RAM.
- tx_valid  input  1  tx_data is valid this cycle.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - state = IDLE, rd_addr_seen = 0, bit counter = 0, shift register = 0.
  - rx_data = 0, rx_valid = 0, miso = 0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX, DONE.
- IDLE:
  - ss_n = 0 -> CHK_CMD; no bit is sampled this cycle.
  - Otherwise stay in IDLE.
- CHK_CMD: sample mosi as frame bit 9, set count = 1, then branch:
  - mosi = 0 -> WRITE.
  - mosi = 1 and rd_addr_seen = 0 -> READ_ADD.
  - mosi = 1 and rd_addr_seen = 1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA, frame capture:
  - Shift in mosi each cycle, count += 1.
  - On the cycle the FRAME_W-th bit is sampled, the next edge loads rx_data = {shift, mosi} and sets rx_valid = 1 for exactly one cycle.
  - Latency is therefore 1 cycle from the last bit sampled to rx_valid.
  - Frame bits [9:8] are forwarded unmodified; the slave does not check opcode/state consistency.
- Exit from the capture states:
  - WRITE -> DONE.
  - READ_ADD -> DONE and sets rd_addr_seen = 1.
  - READ_DATA -> TX and clears rd_addr_seen = 0.
- TX:
  - Wait for tx_valid = 1; tx_valid is expected in the same cycle as rx_valid, because the RAM read is combinational.
  - On that cycle latch tx_data into the output shift register.
  - miso drives bit DATA_W-1 on the next cycle, then one bit per cycle down to bit 0.
  - After DATA_W bits -> DONE.
  - tx_valid arriving later is accepted at any point while in TX.
- DONE: miso = 0; hold until ss_n = 1.
- ss_n = 1 in any non-IDLE state:
  - Next state is IDLE and the bit counter is cleared.
  - A partial frame is discarded: no rx_valid, rx_data unchanged.
  - An in-progress TX is aborted and miso goes to 0.
  - rd_addr_seen is retained across the abort.
- rx_valid never asserts in two consecutive cycles, and never outside a completed frame.
- miso = 0 whenever not in TX with data loaded.
- reset = 1 mid-frame: all state returns to reset values on that edge, including rd_addr_seen = 0; reset takes priority over ss_n.
- An ss_n glitch low for a single cycle reaches CHK_CMD only and produces no output.

Test Plan:
- Write address:
  - Stimulus: ss_n low, mosi = 10'b00_1010_0101, ss_n high.
  - Response: rx_valid one pulse, 1 cycle after the 10th bit, with rx_data = 0x0A5. miso stays 0. Next state is IDLE.
- Write data:
  - Stimulus: frame 10'b01_0011_1100.
  - Response: rx_data = 0x13C with one rx_valid pulse. rd_addr_seen unchanged (0).
- Read sequence:
  - Stimulus: frame 10'b10_0000_0111, then a new frame 10'b11_0000_0000; the bench returns tx_valid = 1 with tx_data = 0xC3 in the same cycle as the second rx_valid.
  - Response: first frame gives rx_data = 0x207 and rd_addr_seen = 1. Second frame routes to READ_DATA, gives rx_data = 0x300, and clears rd_addr_seen. miso then shows 1,1,0,0,0,0,1,1 on the 8 following cycles, then 0.
- Abort:
  - Stimulus: ss_n rises after 6 bits of any frame.
  - Response: no rx_valid, rx_data holds its old value, state = IDLE. A following full frame 0x0FF decodes correctly.
- Reset mid-TX:
  - Stimulus: reset asserted during the 4th MISO bit.
  - Response: miso = 0, rx_valid = 0, rx_data = 0 on the next edge, rd_addr_seen = 0. A subsequent read-data-opcode frame (first bit 1) routes to READ_ADD.
- Back-to-back:
  - Stimulus: two write frames separated by a single ss_n-high cycle.
  - Response: exactly two rx_valid pulses, with the correct rx_data for each.

Source files
------------

// File: rtl/spi_slave_if_if.sv
// SPI slave bus bundle: serial pins plus the parallel word/read-back handshake
// toward the RAM stage.
interface spi_slave_if_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) ();
  logic               ss_n;
  logic               mosi;
  logic               miso;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI frames into opcode+payload words and
// serialises RAM read data back on MISO after a read-data frame.
module spi_slave_if #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input logic            clk,
  input logic            reset,
  spi_slave_if_if.slave  bus
);
  localparam int CNT_W = $clog2(FRAME_W + 1);
  localparam int TXC_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX, DONE
  } state_t;

  state_t             r_state;
  logic               r_rd_addr_seen;
  logic [CNT_W-1:0]   r_cnt;
  logic [FRAME_W-2:0] r_shift;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_miso;
  logic [DATA_W-1:0]  r_tx_sh;
  logic [TXC_W-1:0]   r_tx_cnt;
  logic               r_tx_loaded;

  wire w_last_bit = (r_cnt == CNT_W'(FRAME_W - 1));
  wire w_tx_done  = (r_tx_cnt == TXC_W'(DATA_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_rd_addr_seen <= 1'b0;
      r_cnt          <= '0;
      r_shift        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_miso         <= 1'b0;
      r_tx_sh        <= '0;
      r_tx_cnt       <= '0;
      r_tx_loaded    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      // Deselect anywhere mid-transaction drops the partial frame / read-back
      // but keeps rd_addr_seen so the read pairing survives the abort.
      if (r_state != IDLE && bus.ss_n) begin
        r_state     <= IDLE;
        r_cnt       <= '0;
        r_shift     <= '0;
        r_miso      <= 1'b0;
        r_tx_sh     <= '0;
        r_tx_cnt    <= '0;
        r_tx_loaded <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (!bus.ss_n) r_state <= CHK_CMD;
          end
          CHK_CMD: begin
            r_shift <= {{(FRAME_W-2){1'b0}}, bus.mosi};
            r_cnt   <= CNT_W'(1);
            if (!bus.mosi)           r_state <= WRITE;
            else if (!r_rd_addr_seen) r_state <= READ_ADD;
            else                     r_state <= READ_DATA;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (w_last_bit) begin
              r_rx_data  <= {r_shift, bus.mosi};
              r_rx_valid <= 1'b1;
              r_cnt      <= '0;
              r_shift    <= '0;
              case (r_state)
                READ_ADD: begin
                  r_state        <= DONE;
                  r_rd_addr_seen <= 1'b1;
                end
                READ_DATA: begin
                  r_state        <= TX;
                  r_rd_addr_seen <= 1'b0;
                end
                default: r_state <= DONE;
              endcase
            end else begin
              r_shift <= {r_shift[FRAME_W-3:0], bus.mosi};
              r_cnt   <= r_cnt + 1'b1;
            end
          end
          TX: begin
            // RAM read is combinational, so tx_valid normally lands with rx_valid;
            // a late tx_valid is still accepted here.
            if (!r_tx_loaded) begin
              if (bus.tx_valid) begin
                r_miso      <= bus.tx_data[DATA_W-1];
                r_tx_sh     <= {bus.tx_data[DATA_W-2:0], 1'b0};
                r_tx_cnt    <= TXC_W'(1);
                r_tx_loaded <= 1'b1;
              end
            end else if (w_tx_done) begin
              r_miso      <= 1'b0;
              r_tx_cnt    <= '0;
              r_tx_loaded <= 1'b0;
              r_state     <= DONE;
            end else begin
              r_miso   <= r_tx_sh[DATA_W-1];
              r_tx_sh  <= {r_tx_sh[DATA_W-2:0], 1'b0};
              r_tx_cnt <= r_tx_cnt + 1'b1;
            end
          end
          DONE: begin
            r_miso <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.miso     = r_miso;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
endmodule
